core_regfile: RTL and testbench
===============================

Name: core_regfile

Overview:
- Responder side of the core's register/PC access interface.
- Holds the program counter, the 32-entry integer bank and the 32-entry float bank.
- Serves two registered read ports and one write port, selected by int/float mode bits.
- Adds a per-register busy scoreboard so the issue logic or the bench can see pending writebacks. Sits inside `core` between decode/issue and writeback.

Parameters:
- XLEN, 32, data and PC width.
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rstn  input  1  synchronous active-low reset
- pcenable  input  1  PC update enable
- pcread  input  1  when pcenable=1: 1 loads next_pc, 0 adds PC_STEP
- next_pc  input  XLEN  branch/jump target
- pc  output  XLEN  current PC (register)
- rfmode  input  1  read bank select: 0 int, 1 float (applies to both read ports)
- rreg1  input  5  read port 1 address
- rreg2  input  5  read port 2 address
- reg_out1  output  XLEN  read data 1 (registered)
- reg_out2  output  XLEN  read data 2 (registered)
- busy1  output  1  scoreboard bit for rreg1 (registered, aligned with reg_out1)
- busy2  output  1  scoreboard bit for rreg2 (registered, aligned with reg_out2)
- wenable  input  1  write strobe
- wfmode  input  1  write bank select: 0 int, 1 float
- wreg  input  5  write address
- wdata  input  XLEN  write data
- rsv_en  input  1  reserve strobe: mark destination busy
- rsv_fmode  input  1  reserve bank select
- rsv_reg  input  5  reserve address

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rstn; it is sampled only at the clk rising edge.
- Reset values: pc=PC_RESET; all int and float registers=0; all busy bits=0; reg_out1/2=0; busy1/2=0. Reset overrides every other input in the same cycle.
- PC update:
  - pcenable=0: pc holds.
  - pcenable=1, pcread=1: pc <= next_pc.
  - pcenable=1, pcread=0: pc <= pc + PC_STEP, modulo 2^XLEN. 32'hFFFF_FFFC wraps to 0.
  - pc changes one cycle after the request.
- Reads:
  - Latency 1. reg_out1/2 at edge t+1 reflect rfmode/rreg1/rreg2 sampled at edge t.
  - Reads are issued every cycle; there is no read enable.
- Write:
  - wenable=1 updates bank[wfmode][wreg] at the edge.
  - Integer register 0: writes discarded, reads always 0, never busy.
  - Float register 0 is an ordinary register.
- Bypass: write-first. If at edge t the write matches a read (same bank and address, wenable=1, and not int r0), reg_out gets wdata, not the old value. Both ports bypass independently.
- Scoreboard:
  - rsv_en=1 sets busy[rsv_fmode][rsv_reg].
  - wenable=1 clears busy[wfmode][wreg].
  - Same register reserved and written in the same cycle: the reservation wins and busy ends at 1 (a new producer follows the retiring one).
  - Reserve of int r0 is ignored.
  - Reserving an already-busy register is legal; the bit stays 1 and there is no count.
- busy1/2 use the same bypass rule as data: the sampled value is the post-edge busy state, so a clearing write at edge t yields busy=0 at t+1.
- Mode bits are independent. rfmode and wfmode may differ in the same cycle; bypass applies only on a bank match.
- X inputs on disabled strobes have no effect on state.

Decomposition:
- Shared package core_pkg:
  - XLEN
  - REG_ADDR_W=5
  - BANK_INT=1'b0, BANK_FLT=1'b1
  - PC_STEP
  - PC_RESET
- Sub-module regfile_bank: a single 32xXLEN bank with two registered read ports and one write port with write-first bypass, and a zero-register enable parameter (ZERO_R0 = 1 int, 0 float).
- Top instantiates two regfile_bank instances, muxes outputs by the registered rfmode, and holds the PC and a 2x32 busy vector.

Test Plan:
- Reset/PC: hold rstn=0 two cycles, release with pcenable=1, pcread=0 → pc=0, then 4, 8, 12 on successive cycles. Then pcread=1, next_pc=32'h1000 → pc=32'h1000 next cycle; pcenable=0 → holds 32'h1000.
- Bank isolation: write int r3=32'hA5A5_0001 and float r3=32'h3F80_0000 in consecutive cycles. Read rreg1=3 with rfmode=0, then rfmode=1 → reg_out1=32'hA5A5_0001, then 32'h3F80_0000.
- Zero register: write int r0=32'hDEAD_BEEF, reserve int r0 → reg_out1=0, busy1=0. Write float r0=32'h1 → reads 1.
- Bypass: same cycle, wenable=1, wfmode=0, wreg=5, wdata=32'h55 with rfmode=0, rreg1=5, rreg2=5 → both outputs =32'h55 next cycle. Repeat with rfmode=1 → float r5 old value (0).
- Scoreboard: reserve float r7 → busy=1 on the next read. Write float r7 → busy=0 next read. Simultaneous reserve and write on float r7 → busy=1.
- Mid-operation reset: after writes, reservations and pc=32'h1000, assert rstn=0 for one cycle with wenable=1 → all reads 0, busy 0, pc=0; the write is dropped.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared widths, bank selectors and PC constants for the core
// register/PC access slice.
package core_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic BANK_INT = 1'b0;
  localparam logic BANK_FLT = 1'b1;

  localparam int unsigned     PC_STEP  = 4;
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;
endpackage

// File: rtl/regfile_bank.sv
// regfile_bank: one 32 x DATA_W register bank.
//   clk, rstn       : clock, synchronous active-low reset (clears all entries)
//   wenable/wreg/wdata : write port
//   rreg1/rreg2     : read addresses, sampled every cycle
//   rdata1/rdata2   : registered read data, write-first bypass
// ZERO_R0=1 makes entry 0 hard-wired to zero (writes to it are discarded).
module regfile_bank #(
  parameter int unsigned DATA_W  = 32,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           wenable,
  input  logic [core_pkg::REG_ADDR_W-1:0] wreg,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [core_pkg::REG_ADDR_W-1:0] rreg1,
  input  logic [core_pkg::REG_ADDR_W-1:0] rreg2,
  output logic [DATA_W-1:0]              rdata1,
  output logic [DATA_W-1:0]              rdata2
);
  import core_pkg::*;

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_ok;

  // A write that actually lands; a discarded zero-register write must not bypass.
  assign wr_ok = wenable && !(ZERO_R0 && (wreg == '0));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      if (wr_ok) mem[wreg] <= wdata;

      if (wr_ok && (wreg == rreg1))       rdata1 <= wdata;
      else if (ZERO_R0 && (rreg1 == '0)) rdata1 <= '0;
      else                                rdata1 <= mem[rreg1];

      if (wr_ok && (wreg == rreg2))       rdata2 <= wdata;
      else if (ZERO_R0 && (rreg2 == '0)) rdata2 <= '0;
      else                                rdata2 <= mem[rreg2];
    end
  end
endmodule

// File: rtl/core_regfile.sv
// core_regfile: PC register, integer and float register banks, and a
// per-register busy scoreboard.
//   clk, rstn               : clock, synchronous active-low reset
//   pcenable/pcread/next_pc : PC hold / step by PC_STEP / load target
//   pc                      : current PC
//   rfmode, rreg1, rreg2    : read bank select and addresses (latency 1)
//   reg_out1/2, busy1/2     : read data and busy bits, write-first bypassed
//   wenable/wfmode/wreg/wdata : write port (also clears busy)
//   rsv_en/rsv_fmode/rsv_reg  : reserve port (sets busy, wins over a clear)
module core_regfile #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            pcenable,
  input  logic                            pcread,
  input  logic [XLEN-1:0]                 next_pc,
  output logic [XLEN-1:0]                 pc,
  input  logic                            rfmode,
  input  logic [core_pkg::REG_ADDR_W-1:0] rreg1,
  input  logic [core_pkg::REG_ADDR_W-1:0] rreg2,
  output logic [XLEN-1:0]                 reg_out1,
  output logic [XLEN-1:0]                 reg_out2,
  output logic                            busy1,
  output logic                            busy2,
  input  logic                            wenable,
  input  logic                            wfmode,
  input  logic [core_pkg::REG_ADDR_W-1:0] wreg,
  input  logic [XLEN-1:0]                 wdata,
  input  logic                            rsv_en,
  input  logic                            rsv_fmode,
  input  logic [core_pkg::REG_ADDR_W-1:0] rsv_reg
);
  import core_pkg::*;

  logic [XLEN-1:0]               int_rd1, int_rd2, flt_rd1, flt_rd2;
  logic                          rfmode_q;
  logic [1:0][NUM_REGS-1:0]      busy_q, busy_d;

  regfile_bank #(.DATA_W(XLEN), .ZERO_R0(1'b1)) u_int_bank (
    .clk    (clk),
    .rstn   (rstn),
    .wenable(wenable && (wfmode == BANK_INT)),
    .wreg   (wreg),
    .wdata  (wdata),
    .rreg1  (rreg1),
    .rreg2  (rreg2),
    .rdata1 (int_rd1),
    .rdata2 (int_rd2)
  );

  regfile_bank #(.DATA_W(XLEN), .ZERO_R0(1'b0)) u_flt_bank (
    .clk    (clk),
    .rstn   (rstn),
    .wenable(wenable && (wfmode == BANK_FLT)),
    .wreg   (wreg),
    .wdata  (wdata),
    .rreg1  (rreg1),
    .rreg2  (rreg2),
    .rdata1 (flt_rd1),
    .rdata2 (flt_rd2)
  );

  // Both banks are read every cycle; the bank chosen at the sampling edge
  // is remembered so the registered data can be selected afterwards.
  assign reg_out1 = (rfmode_q == BANK_FLT) ? flt_rd1 : int_rd1;
  assign reg_out2 = (rfmode_q == BANK_FLT) ? flt_rd2 : int_rd2;

  // Clear first, then set: a reserve on the retiring register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (wenable) busy_d[wfmode][wreg] = 1'b0;
    if (rsv_en && !((rsv_fmode == BANK_INT) && (rsv_reg == '0)))
      busy_d[rsv_fmode][rsv_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc       <= PC_RESET;
      rfmode_q <= BANK_INT;
      busy_q   <= '0;
      busy1    <= 1'b0;
      busy2    <= 1'b0;
    end else begin
      if (pcenable) pc <= pcread ? next_pc : pc + XLEN'(PC_STEP);
      rfmode_q <= rfmode;
      busy_q   <= busy_d;
      // Post-edge busy state, matching the write-first data bypass.
      busy1    <= busy_d[rfmode][rreg1];
      busy2    <= busy_d[rfmode][rreg2];
    end
  end
endmodule

// File: tb/tb_core_regfile.sv
module tb_core_regfile;
  typedef struct {
    logic        rstn;
    logic        pcenable;
    logic        pcread;
    logic [31:0] next_pc;
    logic        rfmode;
    logic [4:0]  rreg1;
    logic [4:0]  rreg2;
    logic        wenable;
    logic        wfmode;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        rsv_en;
    logic        rsv_fmode;
    logic [4:0]  rsv_reg;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        b1;
    logic        b2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pcenable = 1'b0, pcread = 1'b0;
  logic [31:0] next_pc = '0;
  logic [31:0] pc;
  logic        rfmode = 1'b0;
  logic [4:0]  rreg1 = '0, rreg2 = '0;
  logic [31:0] reg_out1, reg_out2;
  logic        busy1, busy2;
  logic        wenable = 1'b0, wfmode = 1'b0;
  logic [4:0]  wreg = '0;
  logic [31:0] wdata = '0;
  logic        rsv_en = 1'b0, rsv_fmode = 1'b0;
  logic [4:0]  rsv_reg = '0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t        exp_q[$];

  // Reference state: what the register file architecturally holds.
  logic [31:0] m_pc;
  logic [31:0] m_bank [2][32];
  bit          m_busy [2][32];

  always #5 clk = ~clk;

  core_regfile #(.XLEN(32), .PC_RESET(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rstn(rstn), .pcenable(pcenable), .pcread(pcread),
    .next_pc(next_pc), .pc(pc), .rfmode(rfmode), .rreg1(rreg1), .rreg2(rreg2),
    .reg_out1(reg_out1), .reg_out2(reg_out2), .busy1(busy1), .busy2(busy2),
    .wenable(wenable), .wfmode(wfmode), .wreg(wreg), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_fmode(rsv_fmode), .rsv_reg(rsv_reg)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '{rstn: 1'b1, pcenable: 1'b0, pcread: 1'b0, next_pc: '0, rfmode: 1'b0,
          rreg1: '0, rreg2: '0, wenable: 1'b0, wfmode: 1'b0, wreg: '0, wdata: '0,
          rsv_en: 1'b0, rsv_fmode: 1'b0, rsv_reg: '0};
    return s;
  endfunction

  // Apply one cycle of stimulus and queue the outputs expected after the edge.
  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    rstn = s.rstn; pcenable = s.pcenable; pcread = s.pcread; next_pc = s.next_pc;
    rfmode = s.rfmode; rreg1 = s.rreg1; rreg2 = s.rreg2;
    wenable = s.wenable; wfmode = s.wfmode; wreg = s.wreg; wdata = s.wdata;
    rsv_en = s.rsv_en; rsv_fmode = s.rsv_fmode; rsv_reg = s.rsv_reg;
    if (!s.rstn) begin
      m_pc = 32'h0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 32; r++) begin
          m_bank[b][r] = '0;
          m_busy[b][r] = 1'b0;
        end
    end else begin
      if (s.pcenable) m_pc = s.pcread ? s.next_pc : m_pc + 32'd4;
      if (s.wenable) begin
        if (!(s.wfmode == 1'b0 && s.wreg == 5'd0)) m_bank[s.wfmode][s.wreg] = s.wdata;
        m_busy[s.wfmode][s.wreg] = 1'b0;
      end
      if (s.rsv_en && !(s.rsv_fmode == 1'b0 && s.rsv_reg == 5'd0))
        m_busy[s.rsv_fmode][s.rsv_reg] = 1'b1;
    end
    e.pc = m_pc;
    e.r1 = m_bank[s.rfmode][s.rreg1];
    e.r2 = m_bank[s.rfmode][s.rreg2];
    e.b1 = m_busy[s.rfmode][s.rreg1];
    e.b2 = m_busy[s.rfmode][s.rreg2];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every edge yields one output set; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("reg_out1", reg_out1, e.r1);
        chk("reg_out2", reg_out2, e.r2);
        chk("busy1", {31'd0, busy1}, {31'd0, e.b1});
        chk("busy2", {31'd0, busy2}, {31'd0, e.b2});
      end
    end
  end

  initial begin
    stim_t s;
    // Reset and PC sequencing
    s = idle(); s.rstn = 1'b0;
    drive(s); drive(s);
    s = idle(); s.pcenable = 1'b1;
    drive(s); drive(s); drive(s);
    s.pcread = 1'b1; s.next_pc = 32'h1000; drive(s);
    s = idle(); drive(s); drive(s);

    // Bank isolation
    s = idle(); s.wenable = 1'b1; s.wfmode = 1'b0; s.wreg = 5'd3; s.wdata = 32'hA5A5_0001; drive(s);
    s.wfmode = 1'b1; s.wdata = 32'h3F80_0000; drive(s);
    s = idle(); s.rreg1 = 5'd3; s.rfmode = 1'b0; drive(s);
    s.rfmode = 1'b1; drive(s);

    // Zero register
    s = idle(); s.wenable = 1'b1; s.wreg = 5'd0; s.wdata = 32'hDEAD_BEEF;
    s.rsv_en = 1'b1; s.rsv_reg = 5'd0; drive(s);
    s = idle(); drive(s);
    s.wenable = 1'b1; s.wfmode = 1'b1; s.wreg = 5'd0; s.wdata = 32'h1; drive(s);
    s = idle(); s.rfmode = 1'b1; drive(s);

    // Bypass on both ports, then bank mismatch
    s = idle(); s.wenable = 1'b1; s.wreg = 5'd5; s.wdata = 32'h55; s.rreg1 = 5'd5; s.rreg2 = 5'd5;
    drive(s);
    s.rfmode = 1'b1; s.wdata = 32'h66; drive(s);

    // Scoreboard on float r7
    s = idle(); s.rfmode = 1'b1; s.rreg1 = 5'd7; s.rreg2 = 5'd7;
    s.rsv_en = 1'b1; s.rsv_fmode = 1'b1; s.rsv_reg = 5'd7; drive(s);
    s.rsv_en = 1'b0; drive(s);
    s.wenable = 1'b1; s.wfmode = 1'b1; s.wreg = 5'd7; s.wdata = 32'h77; drive(s);
    s.rsv_en = 1'b1; drive(s);
    s.rsv_en = 1'b0; s.wenable = 1'b0; drive(s);

    // Mid-operation reset with a write pending
    s = idle(); s.rsv_en = 1'b1; s.rsv_reg = 5'd9; drive(s);
    s = idle(); s.rstn = 1'b0; s.wenable = 1'b1; s.wreg = 5'd9; s.wdata = 32'h99;
    s.rreg1 = 5'd9; s.rreg2 = 5'd3; drive(s);
    s = idle(); s.rreg1 = 5'd9; s.rreg2 = 5'd3; drive(s);

    // Randomised traffic, addresses kept narrow to force collisions
    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.rstn      = ($urandom_range(0, 60) != 0);
      s.pcenable  = $urandom_range(0, 1);
      s.pcread    = ($urandom_range(0, 3) == 0);
      s.next_pc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      s.rfmode    = $urandom_range(0, 1);
      s.rreg1     = 5'($urandom_range(0, 7));
      s.rreg2     = 5'($urandom_range(0, 7));
      s.wenable   = $urandom_range(0, 1);
      s.wfmode    = $urandom_range(0, 1);
      s.wreg      = 5'($urandom_range(0, 7));
      s.wdata     = $urandom;
      s.rsv_en    = ($urandom_range(0, 2) == 0);
      s.rsv_fmode = $urandom_range(0, 1);
      s.rsv_reg   = 5'($urandom_range(0, 7));
      drive(s);
    end

    s = idle(); drive(s);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
